eh2_lsu_trigger_hit: RTL

Downstream stage of the LSU data/address trigger matcher. It registers the raw per-trigger dc4 match vector into dc5 and applies per-thread kills. It resolves chained trigger pairs and drives the dc5 trigger-match vector to the debug/exception path. It also accumulates per-thread sticky hit bits and reports them to the TLU through a round-robin valid/ready handshake, so the TLU can set tdata1.hit.

---
 rtl/eh2_lsu_trigger_hit.sv | 122 ++++++++++++
 1 files changed

// File: rtl/eh2_lsu_trigger_hit.sv
// LSU trigger hit stage. It registers the dc4 trigger match into dc5 and
// applies the dc4 and dc5 flush kills. It resolves chained trigger pairs
// (0/1 and 2/3). It also keeps per-thread sticky hit bits, which are
// reported to the TLU through a round-robin valid/ready handshake.
module eh2_lsu_trigger_hit #(
  parameter int unsigned NUM_THREADS = 2,
  parameter int unsigned NUM_TRIG    = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_TRIG-1:0]       lsu_trigger_match_dc4,
  input  logic                      lsu_pkt_valid_dc4,
  input  logic                      lsu_pkt_tid_dc4,
  input  logic [NUM_THREADS-1:0]    lsu_flush_dc4,
  input  logic [NUM_THREADS-1:0]    lsu_flush_dc5,
  input  logic [NUM_THREADS*2-1:0]  trig_chain,
  input  logic [NUM_THREADS*4-1:0]  trig_hit_clr,
  output logic [NUM_TRIG-1:0]       lsu_trigger_match_dc5,
  output logic                      lsu_trigger_tid_dc5,
  output logic                      hit_rpt_valid,
  output logic                      hit_rpt_tid,
  output logic [NUM_TRIG-1:0]       hit_rpt_vec,
  input  logic                      hit_rpt_ready
);

  // Per-thread inputs are zero-padded to two threads.
  // Thread 1 then reads as idle when only one thread exists.
  logic [1:0] flush4;
  logic [1:0] flush5;
  logic [3:0] chain;
  logic [7:0] clr;
  logic       tid_in;

  assign flush4 = 2'(lsu_flush_dc4);
  assign flush5 = 2'(lsu_flush_dc5);
  assign chain  = 4'(trig_chain);
  assign clr    = 8'(trig_hit_clr);
  assign tid_in = (NUM_THREADS > 1) ? lsu_pkt_tid_dc4 : 1'b0;

  logic [3:0] match_q;
  logic       tid_q;
  logic [3:0] hit_pend [2];
  logic [3:0] pend_nxt [2];
  logic       rr_ptr;
  logic       lock_q;
  logic       lock_tid_q;

  logic [1:0] cand;
  logic       sel;
  logic       accept;
  logic [1:0] ch;
  logic [3:0] resolved;

  // dc4 -> dc5 register, killed by the dc4 flush of the packet's thread
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= '0;
      tid_q   <= 1'b0;
    end else begin
      match_q <= (lsu_pkt_valid_dc4 && !flush4[tid_in]) ? lsu_trigger_match_dc4[3:0] : '0;
      tid_q   <= tid_in;
    end
  end

  // Chain resolution followed by the dc5 kill
  always_comb begin
    ch            = chain[{tid_q, 1'b0} +: 2];
    resolved[1:0] = ch[0] ? {2{match_q[0] & match_q[1]}} : match_q[1:0];
    resolved[3:2] = ch[1] ? {2{match_q[2] & match_q[3]}} : match_q[3:2];
    if (flush5[tid_q]) resolved = '0;
  end

  assign lsu_trigger_match_dc5 = NUM_TRIG'(resolved);
  assign lsu_trigger_tid_dc5   = tid_q;

  // Report selection. A report that is offered but not yet accepted stays
  // locked to its thread, even if the other thread becomes a candidate.
  always_comb begin
    cand[0] = |hit_pend[0];
    cand[1] = |hit_pend[1];
    if (lock_q && cand[lock_tid_q]) sel = lock_tid_q;
    else if (cand[0] && cand[1])    sel = rr_ptr;
    else                            sel = cand[1];
  end

  assign hit_rpt_valid = |cand;
  assign hit_rpt_tid   = sel;
  assign hit_rpt_vec   = NUM_TRIG'(hit_pend[sel]);
  assign accept        = hit_rpt_valid & hit_rpt_ready;

  // Sticky accumulation. The clear (TLU write or accepted report) is applied
  // first and the new hits are OR-ed in after it, so a new hit wins over a
  // clear in the same cycle.
  always_comb begin
    for (int unsigned t = 0; t < 2; t++) begin
      pend_nxt[t] = '0;
      if (t < NUM_THREADS) begin
        pend_nxt[t] = hit_pend[t] & ~(clr[t*4 +: 4] |
                      ((accept && (32'(sel) == t)) ? hit_pend[sel] : 4'b0000));
        if (32'(tid_q) == t) pend_nxt[t] = pend_nxt[t] | resolved;
      end
    end
  end

  // Accumulator, round-robin pointer and offer lock
  always_ff @(posedge clk) begin
    if (rst) begin
      hit_pend[0] <= '0;
      hit_pend[1] <= '0;
      rr_ptr      <= 1'b0;
      lock_q      <= 1'b0;
      lock_tid_q  <= 1'b0;
    end else begin
      hit_pend[0] <= pend_nxt[0];
      hit_pend[1] <= pend_nxt[1];
      if (accept) rr_ptr <= (NUM_THREADS > 1) ? ~sel : 1'b0;
      lock_q      <= hit_rpt_valid & ~hit_rpt_ready;
      lock_tid_q  <= sel;
    end
  end

endmodule
